// File: rtl/seq_dispatch.sv
// seq_dispatch: single-issue program sequencer that walks a combinational ROM and strobes device commands.
// Optional call stack for CALL/RET is built only when SEQ_DISPATCH_STACK_EN is defined.
module seq_dispatch #(
   parameter  int ADDR_W  = 8,
   parameter  int DATA_W  = 8,
   parameter  int NDEV    = 8,
   parameter  int NIREG   = 4,
   parameter  int OREG_W  = 12,
   parameter  int STACK_D = 4,
   localparam int INST_W  = OREG_W + 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [INST_W-1:0]       inst,
   input  logic                    inst_en,
   input  logic [NIREG*DATA_W-1:0] ireg,
   input  logic [NDEV-1:0]         dev_busy,
   output logic [ADDR_W-1:0]       next,
   output logic [OREG_W-1:0]       oreg,
   output logic [NDEV-1:0]         oreg_wen,
   output logic                    halted,
   output logic                    error
);

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_SEND = 4'd1;
   localparam logic [3:0] OP_JMP  = 4'd2;
   localparam logic [3:0] OP_JZ   = 4'd3;
   localparam logic [3:0] OP_JNZ  = 4'd4;
   localparam logic [3:0] OP_WAIT = 4'd5;
   localparam logic [3:0] OP_CALL = 4'd6;
   localparam logic [3:0] OP_RET  = 4'd7;
   localparam logic [3:0] OP_HALT = 4'd8;

   if (ADDR_W < 1 || ADDR_W > 12 || ADDR_W > OREG_W || NDEV < 1 || NDEV > 16 ||
       NIREG < 1 || NIREG > 16 || STACK_D < 1 || STACK_D > 16) begin : g_param_check
      $error("seq_dispatch: parameter out of range");
   end

   logic [3:0]        op;
   logic [3:0]        idx;
   logic [OREG_W-1:0] payload;
   logic [ADDR_W-1:0] target, pc_inc;
   logic [DATA_W-1:0] ireg_sel;
   logic              busy_sel, ireg_ok, dev_ok, ireg_zero, fault;

   logic [ADDR_W-1:0] next_q, next_d;
   logic [OREG_W-1:0] oreg_q, oreg_d;
   logic [NDEV-1:0]   wen_q, wen_d;
   logic              halted_q, halted_d, error_q, error_d;

   assign op        = inst[INST_W-1 -: 4];
   assign idx       = inst[INST_W-5 -: 4];
   assign payload   = inst[OREG_W-1:0];
   assign target    = payload[ADDR_W-1:0];
   assign pc_inc    = next_q + ADDR_W'(1);
   assign ireg_ok   = int'(idx) < NIREG;
   assign dev_ok    = int'(idx) < NDEV;
   assign ireg_zero = (ireg_sel == '0);

   always_comb begin
      ireg_sel = '0;
      for (int k = 0; k < NIREG; k++)
         if (idx == k[3:0]) ireg_sel = ireg[k*DATA_W +: DATA_W];
   end

   always_comb begin
      busy_sel = 1'b0;
      for (int k = 0; k < NDEV; k++)
         if (idx == k[3:0]) busy_sel = dev_busy[k];
   end

`ifdef SEQ_DISPATCH_STACK_EN
   localparam int SP_W = $clog2(STACK_D + 1);
   localparam int IX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

   logic [ADDR_W-1:0] stack_q [STACK_D];
   logic [SP_W-1:0]   sp_q, sp_d, sp_dec;
   logic [IX_W-1:0]   wr_ix, rd_ix;
   logic              push, stack_full, stack_empty;

   assign stack_full  = (sp_q == SP_W'(STACK_D));
   assign stack_empty = (sp_q == '0);
   assign sp_dec      = sp_q - SP_W'(1);
   assign wr_ix       = sp_q[IX_W-1:0];
   assign rd_ix       = sp_dec[IX_W-1:0];

   // Return addresses need no reset; only the pointer defines which entries are live.
   always_ff @(posedge clock) begin
      if (push) stack_q[wr_ix] <= pc_inc;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) sp_q <= '0;
      else        sp_q <= sp_d;
   end
`endif

   always_comb begin
      next_d   = next_q;
      oreg_d   = oreg_q;
      wen_d    = '0;
      halted_d = halted_q;
      error_d  = error_q;
      fault    = 1'b0;
`ifdef SEQ_DISPATCH_STACK_EN
      sp_d     = sp_q;
      push     = 1'b0;
`endif
      if (inst_en && !halted_q) begin
         case (op)
            OP_NOP:  next_d = pc_inc;
            OP_SEND: begin
               if (!dev_ok) fault = 1'b1;
               else if (!busy_sel) begin
                  oreg_d = payload;
                  wen_d  = NDEV'(1) << idx;
                  next_d = pc_inc;
               end
            end
            OP_JMP:  next_d = target;
            OP_JZ:   if (!ireg_ok) fault = 1'b1; else next_d = ireg_zero ? target : pc_inc;
            OP_JNZ:  if (!ireg_ok) fault = 1'b1; else next_d = ireg_zero ? pc_inc : target;
            OP_WAIT: if (!ireg_ok) fault = 1'b1; else if (!ireg_zero) next_d = pc_inc;
`ifdef SEQ_DISPATCH_STACK_EN
            OP_CALL: begin
               if (stack_full) fault = 1'b1;
               else begin
                  push   = 1'b1;
                  sp_d   = sp_q + SP_W'(1);
                  next_d = target;
               end
            end
            OP_RET: begin
               if (stack_empty) fault = 1'b1;
               else begin
                  sp_d   = sp_dec;
                  next_d = stack_q[rd_ix];
               end
            end
`endif
            OP_HALT: halted_d = 1'b1;
            default: fault = 1'b1;
         endcase
         if (fault) begin
            halted_d = 1'b1;
            error_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         next_q   <= '0;
         oreg_q   <= '0;
         wen_q    <= '0;
         halted_q <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         next_q   <= next_d;
         oreg_q   <= oreg_d;
         wen_q    <= wen_d;
         halted_q <= halted_d;
         error_q  <= error_d;
      end
   end

   assign next     = next_q;
   assign oreg     = oreg_q;
   assign oreg_wen = wen_q;
   assign halted   = halted_q;
   assign error    = error_q;

endmodule

// File: tb/tb_seq_dispatch.sv
// Scoreboard bench for seq_dispatch: a queue-based program model predicts every post-edge output.
module tb_seq_dispatch;
   localparam int ADDR_W  = 8;
   localparam int DATA_W  = 8;
   localparam int NDEV    = 8;
   localparam int NIREG   = 4;
   localparam int OREG_W  = 12;
   localparam int STACK_D = 4;
   localparam int INST_W  = OREG_W + 8;
   localparam int DEPTH   = 1 << ADDR_W;
   localparam int IRW     = NIREG * DATA_W;
`ifdef SEQ_DISPATCH_STACK_EN
   localparam bit STK = 1'b1;
`else
   localparam bit STK = 1'b0;
`endif

   typedef struct packed {
      logic [ADDR_W-1:0] nxt;
      logic [OREG_W-1:0] oreg;
      logic [NDEV-1:0]   wen;
      logic              halted;
      logic              error;
   } exp_t;

   logic              clock    = 1'b0;
   logic              reset    = 1'b0;
   logic              inst_en  = 1'b0;
   logic [IRW-1:0]    ireg     = '0;
   logic [NDEV-1:0]   dev_busy = '0;
   logic [INST_W-1:0] inst;
   logic [ADDR_W-1:0] next;
   logic [OREG_W-1:0] oreg;
   logic [NDEV-1:0]   oreg_wen;
   logic              halted, error;

   logic [INST_W-1:0] rom [DEPTH];
   exp_t              expq [$];
   int                n_checks = 0;
   int                n_fail   = 0;
   bit                mon_en   = 1'b0;

   int                m_pc;
   int                m_stack [$];
   bit                m_halt, m_err;
   logic [OREG_W-1:0] m_oreg;
   logic [NDEV-1:0]   m_wen;

   always #5 clock = ~clock;
   assign inst = rom[next];

   seq_dispatch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NDEV(NDEV), .NIREG(NIREG),
                  .OREG_W(OREG_W), .STACK_D(STACK_D)) dut (
      .clock(clock), .reset(reset), .inst(inst), .inst_en(inst_en), .ireg(ireg),
      .dev_busy(dev_busy), .next(next), .oreg(oreg), .oreg_wen(oreg_wen),
      .halted(halted), .error(error));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [INST_W-1:0] mk(input int op, input int ix, input int pl);
      return {op[3:0], ix[3:0], pl[OREG_W-1:0]};
   endfunction

   task automatic model_reset();
      m_pc = 0; m_stack.delete(); m_halt = 0; m_err = 0; m_oreg = '0; m_wen = '0;
   endtask

   // Reference behaviour: one instruction per enabled, unhalted edge, straight from the opcode table.
   task automatic model_step();
      logic [INST_W-1:0] w;
      int op, ix, pl, nxt1;
      bit flt, z;
      m_wen = '0;
      flt   = 0;
      if (inst_en && !m_halt) begin
         w    = rom[m_pc];
         op   = int'(w[INST_W-1 -: 4]);
         ix   = int'(w[INST_W-5 -: 4]);
         pl   = int'(w[OREG_W-1:0]) % DEPTH;
         nxt1 = (m_pc + 1) % DEPTH;
         z    = (ix < NIREG) ? (ireg[ix*DATA_W +: DATA_W] == 0) : 1'b0;
         case (op)
            0: m_pc = nxt1;
            1: begin
               if (ix >= NDEV) flt = 1;
               else if (!dev_busy[ix]) begin
                  m_oreg = w[OREG_W-1:0];
                  m_wen  = NDEV'(1 << ix);
                  m_pc   = nxt1;
               end
            end
            2: m_pc = pl;
            3: if (ix >= NIREG) flt = 1; else m_pc = z ? pl : nxt1;
            4: if (ix >= NIREG) flt = 1; else m_pc = z ? nxt1 : pl;
            5: if (ix >= NIREG) flt = 1; else if (!z) m_pc = nxt1;
            6: begin
               if (!STK || m_stack.size() == STACK_D) flt = 1;
               else begin m_stack.push_back(nxt1); m_pc = pl; end
            end
            7: begin
               if (!STK || m_stack.size() == 0) flt = 1;
               else m_pc = m_stack.pop_back();
            end
            8: m_halt = 1;
            default: flt = 1;
         endcase
         if (flt) begin m_halt = 1; m_err = 1; end
      end
      expq.push_back('{ADDR_W'(m_pc), m_oreg, m_wen, m_halt, m_err});
   endtask

   always @(posedge clock) begin
      exp_t e;
      #1;
      if (mon_en) begin
         if (expq.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL sb_empty @%0t: got no expectation, required one", $time);
         end else begin
            e = expq.pop_front();
            chk("next", next, e.nxt);
            chk("oreg", oreg, e.oreg);
            chk("oreg_wen", oreg_wen, e.wen);
            chk("halted", halted, e.halted);
            chk("error", error, e.error);
         end
      end
   end

   task automatic cycle(input bit en, input logic [IRW-1:0] ir, input logic [NDEV-1:0] busy);
      @(negedge clock);
      inst_en = en; ireg = ir; dev_busy = busy;
      model_step();
   endtask

   task automatic run(input int n, input bit en, input logic [IRW-1:0] ir, input logic [NDEV-1:0] busy);
      for (int i = 0; i < n; i++) cycle(en, ir, busy);
   endtask

   task automatic settle();
      @(posedge clock); #2;
   endtask

   // Called just after settle(): reset lands mid-cycle and must clear outputs without a clock edge.
   task automatic assert_reset();
      mon_en = 1'b0;
      reset  = 1'b0;
      #1;
      chk("rst_next", next, 0);
      chk("rst_wen", oreg_wen, 0);
      chk("rst_oreg", oreg, 0);
      chk("rst_halted", halted, 0);
      chk("rst_error", error, 0);
      expq.delete();
      model_reset();
      inst_en = 1'b0;
      for (int a = 0; a < DEPTH; a++) rom[a] = '0;
   endtask

   task automatic release_reset();
      @(negedge clock);
      reset = 1'b1; inst_en = 1'b0; ireg = '0; dev_busy = '0;
      model_step();
      mon_en = 1'b1;
   endtask

   function automatic logic [INST_W-1:0] rand_inst();
      int r, op, ix;
      r  = int'($urandom_range(0, 99));
      op = (r < 3) ? int'($urandom_range(9, 15)) : (r < 6) ? 8 : r % 8;
      ix = (op == 1) ? int'($urandom_range(0, NDEV-1)) : int'($urandom_range(0, NIREG-1));
      if ($urandom_range(0, 19) == 0) ix = int'($urandom_range(0, 15));
      return mk(op, ix, int'($urandom_range(0, (1 << OREG_W) - 1)));
   endfunction

   function automatic logic [IRW-1:0] rand_ireg();
      logic [IRW-1:0] v;
      for (int k = 0; k < NIREG; k++)
         v[k*DATA_W +: DATA_W] = ($urandom_range(0, 1) == 0) ? '0 : DATA_W'($urandom_range(1, 255));
      return v;
   endfunction

   initial begin
      settle();
      assert_reset();

      // Single SEND then HALT.
      rom[0] = mk(1, 2, 'hABC); rom[1] = mk(8, 0, 0);
      release_reset();
      run(4, 1, '0, '0);
      settle();
      chk("s1_next", next, 1); chk("s1_halted", halted, 1);
      chk("s1_error", error, 0); chk("s1_oreg", oreg, 'hABC);
      assert_reset();

      // Busy device stalls five cycles; reset then lands on the strobe cycle.
      rom[0] = mk(1, 1, 'h123); rom[1] = mk(8, 0, 0);
      release_reset();
      run(5, 1, '0, 8'h02);
      settle();
      chk("s2_stall_next", next, 0); chk("s2_stall_wen", oreg_wen, 0);
      cycle(1, '0, '0);
      settle();
      chk("s2_strobe", oreg_wen, 8'h02); chk("s2_oreg", oreg, 'h123);
      assert_reset();

      // JZ taken / not taken.
      rom[0] = mk(3, 0, 'h040); rom[1] = mk(8, 0, 0); rom['h40] = mk(8, 0, 0);
      release_reset();
      run(1, 1, '0, '0);
      settle();
      chk("s3_jz_taken", next, 'h40);
      assert_reset();
      rom[0] = mk(3, 0, 'h040); rom[1] = mk(8, 0, 0);
      release_reset();
      run(2, 1, IRW'(1), '0);
      settle();
      chk("s3_jz_fall", next, 1);
      assert_reset();

      // Five nested CALLs overflow the stack.
      rom[0] = mk(6, 0, 'h10); rom['h10] = mk(6, 0, 'h20); rom['h20] = mk(6, 0, 'h30);
      rom['h30] = mk(6, 0, 'h40); rom['h40] = mk(6, 0, 'h50);
      release_reset();
      run(7, 1, '0, '0);
      settle();
      chk("s4_ovf_error", error, 1); chk("s4_ovf_halted", halted, 1);
      assert_reset();

      // Four CALLs unwound by four RETs.
      rom[0] = mk(6, 0, 'h10); rom['h10] = mk(6, 0, 'h20); rom['h20] = mk(6, 0, 'h30);
      rom['h30] = mk(6, 0, 'h40); rom['h40] = mk(7, 0, 0); rom['h31] = mk(7, 0, 0);
      rom['h21] = mk(7, 0, 0); rom['h11] = mk(7, 0, 0); rom[1] = mk(8, 0, 0);
      release_reset();
      run(11, 1, '0, '0);
      settle();
      chk("s4_ret_error", error, STK ? 0 : 1); chk("s4_ret_next", next, STK ? 1 : 0);
      assert_reset();
      rom[0] = mk(7, 0, 0);
      release_reset();
      run(2, 1, '0, '0);
      settle();
      chk("s4_ret_empty", error, 1);
      assert_reset();

      // Wrap at the top of the address space, then an illegal opcode.
      rom[0] = mk(2, 0, 'hFF); rom['hFF] = mk(0, 0, 0); rom[1] = mk(12, 0, 0);
      release_reset();
      run(2, 1, '0, '0);
      settle();
      chk("s5_wrap", next, 0); chk("s5_wrap_halted", halted, 0);
      assert_reset();
      rom[0] = mk(12, 0, 0);
      release_reset();
      run(2, 1, '0, '0);
      settle();
      chk("s5_illegal", error, 1);
      assert_reset();

      // Out-of-range SEND, WAIT, and inst_en freeze overriding a stall.
      rom[0] = mk(1, 9, 'h55);
      release_reset();
      run(2, 1, '0, '0);
      settle();
      chk("send_badidx_err", error, 1); chk("send_badidx_wen", oreg_wen, 0);
      assert_reset();
      rom[0] = mk(5, 2, 0); rom[1] = mk(1, 3, 'h777); rom[2] = mk(8, 0, 0);
      release_reset();
      run(3, 1, '0, '0);
      run(2, 0, IRW'(32'h0005_0000), 8'h08);
      run(2, 1, IRW'(32'h0005_0000), 8'h08);
      run(1, 0, IRW'(32'h0005_0000), '0);
      run(3, 1, '0, '0);
      settle();
      chk("wait_send_oreg", oreg, 'h777); chk("wait_send_next", next, 2);

      for (int r = 0; r < 40; r++) begin
         assert_reset();
         for (int a = 0; a < DEPTH; a++) rom[a] = rand_inst();
         release_reset();
         for (int c = 0; c < 50; c++)
            cycle($urandom_range(0, 9) != 0, rand_ireg(), NDEV'($urandom & $urandom));
         settle();
      end
      chk("sb_drain", expq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/seq_dispatch.md
SEQ_DISPATCH -- requirements
Module: seq_dispatch

Interface
REQ-001 Parameter ADDR_W, default 8: program address width, range 1..12.
REQ-002 Parameter DATA_W, default 8: width of each input register.
REQ-003 Parameter NDEV, default 8: number of output devices, range 1..16.
REQ-004 Parameter NIREG, default 4: number of input registers, range 1..16.
REQ-005 Parameter OREG_W, default 12: device command width; INST_W = OREG_W + 8.
REQ-006 Parameter STACK_D, default 4: call stack depth, range 1..16.
REQ-007 clock  in  1  single clock; all state updates on its rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 inst  in  INST_W  instruction at address next: opcode [INST_W-1:INST_W-4], idx [INST_W-5:INST_W-8], payload [OREG_W-1:0].
REQ-010 inst_en  in  1  execute enable; low means the block holds all state.
REQ-011 ireg  in  NIREG*DATA_W  flattened input registers; register k is bits [k*DATA_W +: DATA_W].
REQ-012 dev_busy  in  NDEV  per-device busy flag; bit d is high while device d cannot accept a command.
REQ-013 next  out  ADDR_W  registered program counter, fed to the program ROM.
REQ-014 oreg  out  OREG_W  registered device command.
REQ-015 oreg_wen  out  NDEV  registered one-hot command strobe.
REQ-016 halted  out  1  high once HALT executes or a fault occurs.
REQ-017 error  out  1  sticky fault flag.

Function
REQ-018 The block SHALL execute one instruction per rising edge when inst_en=1, halted=0 and no stall condition holds.
REQ-019 Addressing SHALL be combinational: the ROM returns inst for next in the same cycle.
REQ-020 The block SHALL support these opcodes.
- 0 NOP: next+1.
- 1 SEND: next+1.
- 2 JMP: next=payload[ADDR_W-1:0].
- 3 JZ: jump if ireg[idx]==0, else next+1.
- 4 JNZ: jump if ireg[idx]!=0, else next+1.
- 5 WAIT: stall while ireg[idx]==0, then next+1.
- 6 CALL.
- 7 RET.
- 8 HALT.
REQ-021 SEND with dev_busy[idx]=0 SHALL drive oreg=payload and oreg_wen=1<<idx for exactly the cycle after the executing edge.
REQ-022 SEND with dev_busy[idx]=1 SHALL stall: next is held and oreg_wen stays 0 until dev_busy[idx]=0.
REQ-023 oreg_wen SHALL be 0 on every cycle that does not immediately follow an executed SEND; oreg SHALL hold its last value.
REQ-024 SEND with idx>=NDEV, or JZ/JNZ/WAIT with idx>=NIREG, SHALL set error=1 and halted=1 without a strobe.
REQ-025 Opcodes 9..15 SHALL set error=1 and halted=1.
REQ-026 next SHALL wrap from 2^ADDR_W-1 to 0 on increment.
REQ-027 CALL SHALL push next+1 and jump to payload; CALL with the stack full (STACK_D entries) SHALL set error=1 and halted=1, leaving the stack unchanged.
REQ-028 RET SHALL pop into next; RET with the stack empty SHALL set error=1 and halted=1.
REQ-029 HALT SHALL set halted=1 and hold next at the HALT address; only reset clears halted.
REQ-030 inst_en=0 SHALL freeze next, the stack and the flags, and force oreg_wen=0 on the following cycle.
REQ-031 A stall and inst_en=0 occurring together SHALL behave as inst_en=0.

Reset
REQ-032 Assertion of reset (low) SHALL asynchronously set next=0, oreg=0, oreg_wen=0, stack pointer=0, halted=0 and error=0, including mid-stall or mid-strobe.
REQ-033 The first instruction SHALL execute on the first rising edge after reset deasserts with inst_en=1.

Configuration
REQ-034 With macro SEQ_DISPATCH_STACK_EN defined, CALL/RET and the STACK_D-entry stack SHALL be implemented as specified.
REQ-035 Without SEQ_DISPATCH_STACK_EN, no stack storage SHALL exist; CALL and RET SHALL set error=1 and halted=1 like an illegal opcode.

Verification
REQ-036 Scenario 1: reset, then ROM {0:SEND idx=2 payload=0xABC, 1:HALT} -> oreg_wen=0x04 and oreg=0xABC for one cycle; next holds 1; halted=1, error=0.
REQ-037 Scenario 2: SEND idx=1 with dev_busy[1]=1 for 5 cycles -> next held and oreg_wen=0 for 5 cycles; strobe 0x02 on the cycle after busy drops.
REQ-038 Scenario 3: JZ idx=0 target 0x40 with ireg[0]=0 -> next=0x40; repeat with ireg[0]=0x01 -> next increments.
REQ-039 Scenario 4: stack enabled, STACK_D=4, five nested CALLs -> fifth sets error=1, halted=1; then four RETs from a fresh run with four CALLs return to the correct addresses in order.
REQ-040 Scenario 5: instruction at 0xFF is NOP -> next wraps to 0x00; opcode 0xC -> error=1, halted=1.
REQ-041 Scenario 6: assert reset during a SEND strobe cycle -> oreg_wen=0 and next=0 immediately, without waiting for a clock edge.
